// File: rtl/bayer_scan_ctrl_if.sv
// Window stream bundle between the white-balance stage, the raster sequencer
// and the downstream RGGB reorder mux.
interface bayer_scan_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] wb_1, wb_2, wb_3, wb_4;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] wb_q_1, wb_q_2, wb_q_3, wb_q_4;
    logic       row, col;
    logic       sof, eol, eof;

    modport master (
        output in_valid, wb_1, wb_2, wb_3, wb_4, out_ready,
        input  in_ready, out_valid, wb_q_1, wb_q_2, wb_q_3, wb_q_4,
               row, col, sof, eol, eof
    );

    modport slave (
        input  in_valid, wb_1, wb_2, wb_3, wb_4, out_ready,
        output in_ready, out_valid, wb_q_1, wb_q_2, wb_q_3, wb_q_4,
               row, col, sof, eol, eof
    );
endinterface

// File: rtl/bayer_scan_ctrl.sv
// Raster sequencer for the white-balance -> Bayer-reorder stage: registers each
// window with its row/col parity selects and frame markers, and sequences frames.
module bayer_scan_ctrl #(
    parameter int DIM_BITS = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [DIM_BITS-1:0] img_width,
    input  logic [DIM_BITS-1:0] img_height,
    input  logic [1:0]          phase,
    bayer_scan_ctrl_if.slave    bus,
    output logic                busy,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [DIM_BITS-1:0] cfg_w, cfg_h;
    logic [1:0]          cfg_phase;
    logic [DIM_BITS-1:0] col_cnt, row_cnt;

    logic accept, handoff, at_eol, at_eof;

    // Single output register with pass-through refill: a slot frees up in the
    // same cycle the downstream takes the current window.
    assign bus.in_ready = (state == ST_RUN) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign handoff      = bus.out_valid && bus.out_ready;
    assign at_eol       = (col_cnt == cfg_w - DIM_BITS'(1));
    assign at_eof       = at_eol && (row_cnt == cfg_h - DIM_BITS'(1));
    assign busy         = (state != ST_IDLE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            cfg_w         <= '0;
            cfg_h         <= '0;
            cfg_phase     <= '0;
            col_cnt       <= '0;
            row_cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.wb_q_1    <= '0;
            bus.wb_q_2    <= '0;
            bus.wb_q_3    <= '0;
            bus.wb_q_4    <= '0;
            bus.row       <= 1'b0;
            bus.col       <= 1'b0;
            bus.sof       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.eof       <= 1'b0;
            frame_done    <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (img_width != '0 && img_height != '0) begin
                            cfg_w     <= img_width;
                            cfg_h     <= img_height;
                            cfg_phase <= phase;
                            col_cnt   <= '0;
                            row_cnt   <= '0;
                            state     <= ST_RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.wb_q_1    <= bus.wb_1;
                        bus.wb_q_2    <= bus.wb_2;
                        bus.wb_q_3    <= bus.wb_3;
                        bus.wb_q_4    <= bus.wb_4;
                        bus.row       <= row_cnt[0] ^ cfg_phase[1];
                        bus.col       <= col_cnt[0] ^ cfg_phase[0];
                        bus.sof       <= (row_cnt == '0) && (col_cnt == '0);
                        bus.eol       <= at_eol;
                        bus.eof       <= at_eof;
                        // Counters wrap to zero on the final window so they
                        // never leave the programmed frame.
                        if (at_eol) begin
                            col_cnt <= '0;
                            row_cnt <= at_eof ? '0 : row_cnt + DIM_BITS'(1);
                        end else begin
                            col_cnt <= col_cnt + DIM_BITS'(1);
                        end
                        if (at_eof) state <= ST_DRAIN;
                    end else if (handoff) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (handoff) begin
                        bus.out_valid <= 1'b0;
                        frame_done    <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bayer_scan_ctrl.sv
// Randomized scoreboard bench for bayer_scan_ctrl: the driver pushes expected
// windows computed from the raster index, a monitor pops them on handoff.
module tb_bayer_scan_ctrl;

    localparam int DIM_BITS = 10;

    typedef struct packed {
        logic [7:0] d1, d2, d3, d4;
        logic       row, col, sof, eol, eof;
    } win_t;

    logic                clk;
    logic                n_rst;
    logic                start;
    logic [DIM_BITS-1:0] img_width, img_height;
    logic [1:0]          phase;
    logic                busy, frame_done, cfg_err;

    bayer_scan_ctrl_if bus ();

    bayer_scan_ctrl #(.DIM_BITS(DIM_BITS)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .phase      (phase),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    win_t exp_q[$];
    int   fd_count   = 0;
    int   win_idx    = 0;
    int   stall_at   = -1;
    int   stall_left = 0;
    bit   rdy_rand   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic win_t dut_window();
        win_t w;
        w.d1  = bus.wb_q_1;
        w.d2  = bus.wb_q_2;
        w.d3  = bus.wb_q_3;
        w.d4  = bus.wb_q_4;
        w.row = bus.row;
        w.col = bus.col;
        w.sof = bus.sof;
        w.eol = bus.eol;
        w.eof = bus.eof;
        return w;
    endfunction

    // Monitor: pops on every handoff, checks stall stability and frame_done timing.
    initial begin
        win_t held, act, e;
        bit   holding   = 0;
        bit   expect_fd = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                holding   = 0;
                expect_fd = 0;
                win_idx   = 0;
                continue;
            end
            check("frame_done", frame_done, expect_fd);
            if (frame_done) begin
                fd_count++;
                check("busy_after_done", busy, 0);
            end
            expect_fd = 0;
            if (bus.out_valid) begin
                act = dut_window();
                if (holding) check("hold_stable", act, held);
                if (bus.out_ready) begin
                    holding = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_window: got %0h expected none", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", act, e);
                        if (e.eof) begin
                            expect_fd = 1;
                            win_idx   = 0;
                        end else begin
                            win_idx++;
                        end
                    end
                end else begin
                    held    = act;
                    holding = 1;
                    check("stall_in_ready", bus.in_ready, 0);
                end
            end else begin
                holding = 0;
            end
        end
    end

    // Downstream ready: scripted 3-cycle stall at a chosen window, else high or random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (stall_at >= 0 && bus.out_valid && win_idx == stall_at) begin
                stall_at      = -1;
                bus.out_ready = 1'b0;
                stall_left    = 2;
            end else begin
                bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic new_data();
        bus.wb_1 = 8'($urandom);
        bus.wb_2 = 8'($urandom);
        bus.wb_3 = 8'($urandom);
        bus.wb_4 = 8'($urandom);
    endtask

    // Runs one frame; abort_after>0 stops feeding after that many accepts.
    task automatic do_frame(input int w, input int h, input logic [1:0] ph, input bit gaps,
                            input bit check_tput, input int restart_at, input int abort_after);
        int   n = w * h;
        int   k = 0;
        int   cycles = 0;
        int   fd_before = fd_count;
        bit   done = 0;
        win_t e;
        @(posedge clk); #1;
        start = 1'b1; img_width = DIM_BITS'(w); img_height = DIM_BITS'(h); phase = ph;
        @(posedge clk); #1;
        start = 1'b0; img_width = DIM_BITS'($urandom); img_height = DIM_BITS'($urandom);
        phase = 2'($urandom);
        bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        new_data();
        while (k < n && cycles < 2000) begin
            @(negedge clk);
            if (cycles == 0) check("busy_rise", busy, 1);
            if (bus.in_valid && bus.in_ready) begin
                e.d1 = bus.wb_1; e.d2 = bus.wb_2; e.d3 = bus.wb_3; e.d4 = bus.wb_4;
                e.row = 1'(((k / w) % 2)) ^ ph[1];
                e.col = 1'(((k % w) % 2)) ^ ph[0];
                e.sof = (k == 0);
                e.eol = ((k % w) == w - 1);
                e.eof = (k == n - 1);
                exp_q.push_back(e);
                k++;
                if (abort_after > 0 && k == abort_after) return;
                if (k < n) begin
                    @(posedge clk); #1; cycles++;
                    new_data();
                end
            end else begin
                @(posedge clk); #1; cycles++;
            end
            if (k == n) break;
            start = (k == restart_at);
            if (start) begin
                img_width  = DIM_BITS'(2);
                img_height = DIM_BITS'(2);
            end
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        start = 1'b0;
        if (k < n) begin
            total++; bad++;
            $display("FAIL accept_timeout: got %0d windows expected %0d", k, n);
        end
        if (check_tput) check("throughput_cycles", cycles, n - 1);
        // Keep offering windows during drain: none may be taken past eof.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            check("drain_in_ready", bus.in_ready, 0);
            if (fd_count > fd_before) begin
                done = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL frame_done_timeout: got none expected pulse");
        end
        check("frame_done_count", fd_count, fd_before + 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check(name, {bus.in_ready, bus.out_valid, bus.wb_q_1, bus.wb_q_2, bus.wb_q_3,
                     bus.wb_q_4, bus.row, bus.col, bus.sof, bus.eol, bus.eof,
                     busy, frame_done, cfg_err}, 0);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; img_width = '0; img_height = '0; phase = '0;
        bus.in_valid = 1'b0;
        bus.wb_1 = '0; bus.wb_2 = '0; bus.wb_3 = '0; bus.wb_4 = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_values");
        @(posedge clk); #1;
        n_rst = 1'b1;

        do_frame(4, 2, 2'b00, 0, 1, -1, 0);
        do_frame(4, 2, 2'b11, 0, 1, -1, 0);

        stall_at = 2;
        do_frame(3, 2, 2'b00, 0, 0, -1, 0);

        @(posedge clk); #1;
        start = 1'b1; img_width = '0; img_height = DIM_BITS'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 0);
        check("cfg_err_busy_stays", busy, 0);

        do_frame(1, 1, 2'b00, 0, 1, -1, 0);
        do_frame(5, 3, 2'b01, 0, 1, 4, 0);

        rdy_rand = 1;
        for (int r = 0; r < 6; r++)
            do_frame($urandom_range(1, 6), $urandom_range(1, 4), 2'($urandom), 1, 0, -1, 0);
        rdy_rand = 0;

        do_frame(4, 4, 2'b10, 0, 0, -1, 6);
        @(posedge clk); #1;
        n_rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_values("midframe_reset_values");
        exp_q.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
        do_frame(4, 4, 2'b00, 0, 1, -1, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bayer_scan_ctrl.md
# bayer_scan_ctrl

Raster sequencer for the white-balance → Bayer-reorder stage. Accepts a stream of four-channel pixel windows (wb_1..wb_4) over a valid/ready handshake, tracks column/row position over a programmed frame size, and presents each registered window with its row/col parity selects to the downstream RGGB reorder mux. It also generates start-of-frame, end-of-line and end-of-frame markers and a frame-complete pulse, and it owns frame start/stop sequencing for that stage.

## Interface
- DIM_BITS, 10, width of the frame dimension inputs and position counters
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- img_width  in  DIM_BITS  pixels per line; latched on an accepted start
- img_height  in  DIM_BITS  lines per frame; latched on an accepted start
- phase  in  2  Bayer phase offset {row_inv, col_inv}; latched on an accepted start
- in_valid  in  1  upstream window valid
- in_ready  out  1  window accepted when in_valid && in_ready
- wb_1, wb_2, wb_3, wb_4  in  8 each  white-balanced channel values
- out_valid  out  1  registered window valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- wb_q_1..wb_q_4  out  8 each  registered channel values
- row  out  1  row parity select for the reorder mux
- col  out  1  column parity select for the reorder mux
- sof, eol, eof  out  1 each  markers qualified by out_valid
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse when the final window is handed off
- cfg_err  out  1  one-cycle pulse when start is rejected for a zero dimension

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. On start with img_width≠0 and img_height≠0, latch the dimensions and phase, clear col_cnt/row_cnt, and go to RUN. On start with either dimension 0, pulse cfg_err and stay in IDLE.
- RUN: in_ready = !out_valid || out_ready. This is a single output register with pass-through refill, so the stage sustains one window per cycle.
- On accept:
  - Load wb_q_* from the wb_* inputs.
  - row = row_cnt[0] ^ phase[1]; col = col_cnt[0] ^ phase[0].
  - sof = (row_cnt==0 && col_cnt==0); eol = (col_cnt==W-1); eof = eol && (row_cnt==H-1).
  - Set out_valid.
- Counter advance on accept: if col_cnt==W-1, col_cnt←0 and row_cnt←row_cnt+1; otherwise col_cnt←col_cnt+1.
- An accept with eof moves the FSM to DRAIN; in_ready=0 from the next cycle.
- DRAIN: when out_valid && out_ready, pulse frame_done, clear out_valid, and go to IDLE.
- Output handshake outside accepts: out_valid && out_ready with no new accept clears out_valid. While out_valid && !out_ready, all out_* signals hold stable.
- start in RUN or DRAIN is ignored; the latched configuration does not change mid-frame.
- W=1 is legal: every window has eol=1. W=1 and H=1 is legal: the first window carries sof, eol and eof together.
- Counters never exceed W-1 / H-1; no accepts occur past eof.

## Timing
- Reset values: state=IDLE; in_ready=0, out_valid=0, wb_q_*=0, row=0, col=0, sof=eol=eof=0, busy=0, frame_done=0, cfg_err=0; counters and latched configuration are 0.
- Reset asserted mid-frame aborts immediately: the current window is dropped and no frame_done is issued.
- Latency: an accept at edge N makes out_valid and its data/markers visible after edge N.
- busy rises the cycle after an accepted start and falls the cycle after the frame_done edge.
- The earliest first accept is one cycle after the accepted start edge.
- A new start is accepted in the cycle after the frame_done pulse, at the earliest.
- frame_done and cfg_err are registered single-cycle pulses.

## Test plan
- W=4, H=2, phase=00, in_valid and out_ready held high → 8 windows on consecutive cycles.
  - (row,col) sequence: 00,01,00,01,10,11,10,11.
  - sof on window 0; eol on windows 3 and 7; eof on window 7.
  - frame_done one cycle after window 7 is handed off.
- Same frame with phase=11 → (row,col) sequence inverted: 11,10,11,10,01,00,01,00.
- W=3, H=2 with out_ready low for 3 cycles at window 2 → wb_q_*, row, col and markers hold; in_ready=0 during the stall; no window is lost or duplicated; col wraps 2→0 correctly.
- start with img_width=0 → cfg_err pulse, busy stays 0. Then W=1, H=1 → a single window with sof=eol=eof=1, followed by frame_done.
- start pulsed during RUN with different dimensions → ignored; frame ends on the original count.
- n_rst asserted after window 5 of a 4x4 frame → all outputs take reset values; a fresh start then begins with sof at (0,0).
